// File: rtl/sccb_init_pkg.sv
// Shared types for the SCCB init sequencer: FSM states, table markers and the ROM entry layout.
package sccb_init_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    WRITE,
    DELAY,
    READ,
    CHECK,
    NEXT,
    FINISH
  } state_t;

  localparam logic [7:0] MARK_ADDR = 8'hFF;
  localparam logic [7:0] MARK_END  = 8'hFF;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } tbl_entry_t;

endpackage

// File: rtl/sccb_tick_gen.sv
// Free-running SCCB bit-rate tick: one-Clk pulse every DIV cycles, first pulse DIV cycles after reset.
module sccb_tick_gen #(
  parameter int DIV = 125
) (
  input  logic Clk,
  input  logic Reset,
  output logic tick
);

  logic [15:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == 16'(DIV - 1));
      if (cnt == 16'(DIV - 1)) cnt <= '0;
      else                     cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Table-driven OV7670 initialiser: one SCCB write per ROM entry with NACK retry, inline delay/end markers.
// Define SCCB_INIT_READBACK_EN to read each register back and count mismatches.
module sccb_init_sequencer
  import sccb_init_pkg::*;
#(
  parameter int  DEPTH     = 32,
  parameter int  DIV       = 125,
  parameter int  MAX_RETRY = 3,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sccb_tick,
  output logic              sccb_req,
  output logic              sccb_rd,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_ack,
  input  logic              sccb_nack,
  input  logic [7:0]        sccb_rdata,
  output logic [7:0]        mismatch_cnt
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  index, index_n;
  tbl_entry_t         entry, entry_n, tbl_in;
  logic [7:0]         delay_cnt, delay_n;
  logic [RETRY_W-1:0] retry_cnt, retry_n;
  logic               gap, gap_n;
  logic               error_n;
  logic               in_xfer, nack_hit, ack_hit, retry_ok;

  sccb_tick_gen #(.DIV(DIV)) u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .tick  (sccb_tick)
  );

  assign tbl_in     = tbl_data;
  assign tbl_addr   = index;
  assign sccb_addr  = entry.reg_addr;
  assign sccb_wdata = entry.reg_data;

  // gap forces one low request cycle between back-to-back attempts so the master sees a fresh edge
  assign in_xfer  = (state == WRITE) || (state == READ);
  assign sccb_req = in_xfer && !gap;
  assign nack_hit = sccb_req && sccb_nack;
  assign ack_hit  = sccb_req && sccb_ack && !sccb_nack;
  assign retry_ok = retry_cnt < RETRY_W'(MAX_RETRY);
  assign busy     = (state != IDLE) && (state != FINISH);
  assign done     = (state == FINISH);

`ifdef SCCB_INIT_READBACK_EN
  logic [7:0] mm_q, mm_n, rdata_q, rdata_n;
  assign sccb_rd      = (state == READ);
  assign mismatch_cnt = mm_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^sccb_rdata;
  assign sccb_rd      = 1'b0;
  assign mismatch_cnt = 8'd0;
`endif

  always_comb begin
    state_n   = state;
    index_n   = index;
    entry_n   = entry;
    delay_n   = delay_cnt;
    retry_n   = retry_cnt;
    gap_n     = 1'b0;
    error_n   = error;
`ifdef SCCB_INIT_READBACK_EN
    mm_n      = mm_q;
    rdata_n   = rdata_q;
`endif

    if (nack_hit) begin
      if (retry_ok) begin
        retry_n = retry_cnt + RETRY_W'(1);
        gap_n   = 1'b1;
      end else begin
        error_n = 1'b1;
        state_n = FINISH;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          index_n = '0;
          error_n = 1'b0;
`ifdef SCCB_INIT_READBACK_EN
          mm_n    = 8'd0;
`endif
        end
      end
      FETCH: state_n = DECODE;
      DECODE: begin
        entry_n = tbl_in;
        retry_n = '0;
        if (tbl_in.reg_addr == MARK_ADDR) begin
          if (tbl_in.reg_data == MARK_END)   state_n = FINISH;
          else if (tbl_in.reg_data == 8'd0)  state_n = NEXT;
          else begin
            delay_n = tbl_in.reg_data;
            state_n = DELAY;
          end
        end else begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (ack_hit) begin
`ifdef SCCB_INIT_READBACK_EN
          retry_n = '0;
          gap_n   = 1'b1;
          state_n = READ;
`else
          state_n = NEXT;
`endif
        end
      end
`ifdef SCCB_INIT_READBACK_EN
      READ: begin
        if (ack_hit) begin
          rdata_n = sccb_rdata;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (rdata_q != entry.reg_data && mm_q != 8'hFF) mm_n = mm_q + 8'd1;
        state_n = NEXT;
      end
`endif
      DELAY: begin
        if (sccb_tick) begin
          if (delay_cnt == 8'd1) state_n = NEXT;
          else                   delay_n = delay_cnt - 8'd1;
        end
      end
      NEXT: begin
        if (index == ADDR_W'(DEPTH - 1)) begin
          state_n = FINISH;
        end else begin
          index_n = index + ADDR_W'(1);
          state_n = FETCH;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      index     <= '0;
      entry     <= '0;
      delay_cnt <= 8'd0;
      retry_cnt <= '0;
      gap       <= 1'b0;
      error     <= 1'b0;
`ifdef SCCB_INIT_READBACK_EN
      mm_q      <= 8'd0;
      rdata_q   <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      index     <= index_n;
      entry     <= entry_n;
      delay_cnt <= delay_n;
      retry_cnt <= retry_n;
      gap       <= gap_n;
      error     <= error_n;
`ifdef SCCB_INIT_READBACK_EN
      mm_q      <= mm_n;
      rdata_q   <= rdata_n;
`endif
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench: a table-walking reference model predicts SCCB requests and end-of-pass status.
module tb_sccb_init_sequencer;

  localparam int DEPTH     = 8;
  localparam int DIV       = 8;
  localparam int MAX_RETRY = 3;
  localparam int ADDR_W    = $clog2(DEPTH);

  logic              Clk = 1'b0;
  logic              Reset;
  logic              start;
  logic              busy, done, error;
  logic [ADDR_W-1:0] tbl_addr;
  logic [15:0]       tbl_data = 16'h0;
  logic              sccb_tick, sccb_req, sccb_rd;
  logic [7:0]        sccb_addr, sccb_wdata;
  logic              sccb_ack, sccb_nack;
  logic [7:0]        sccb_rdata;
  logic [7:0]        mismatch_cnt;

  sccb_init_sequencer #(.DEPTH(DEPTH), .DIV(DIV), .MAX_RETRY(MAX_RETRY)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .busy(busy), .done(done), .error(error),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .sccb_tick(sccb_tick), .sccb_req(sccb_req),
    .sccb_rd(sccb_rd), .sccb_addr(sccb_addr), .sccb_wdata(sccb_wdata), .sccb_ack(sccb_ack),
    .sccb_nack(sccb_nack), .sccb_rdata(sccb_rdata), .mismatch_cnt(mismatch_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic [7:0] addr; logic [7:0] wdata; logic rd; } req_t;
  typedef struct packed { logic ack; logic nack; logic [7:0] rdata; } resp_t;
  typedef struct { logic err; int mm; int last; } pass_t;

  logic [15:0] rom [DEPTH];
  req_t  exp_req_q[$];
  resp_t plan_q[$];
  resp_t forced_q[$];
  pass_t exp_pass_q[$];
  int    stamps[$];
  int    vectors = 0, miscompares = 0;
  int    cyc = 0, dones = 0, max_idx = 0;
  logic  prev_req = 1'b0;

  always @(posedge Clk) tbl_data <= rom[tbl_addr];
  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every fresh request edge and every done pulse is compared against the scoreboard.
  always @(negedge Clk) begin
    req_t  e;
    pass_t p;
    if (Reset) begin
      prev_req = 1'b0;
      max_idx  = 0;
    end else begin
      if (busy && int'(tbl_addr) > max_idx) max_idx = int'(tbl_addr);
      if (sccb_req && !prev_req) begin
        stamps.push_back(cyc);
        check("request_expected", exp_req_q.size() > 0, 1);
        if (exp_req_q.size() > 0) begin
          e = exp_req_q.pop_front();
          check("req_addr", sccb_addr, e.addr);
          check("req_rd", sccb_rd, e.rd);
          if (!e.rd) check("req_wdata", sccb_wdata, e.wdata);
        end
      end
      prev_req = sccb_req;
      if (done) begin
        check("done_expected", exp_pass_q.size() > 0, 1);
        if (exp_pass_q.size() > 0) begin
          p = exp_pass_q.pop_front();
          check("pass_error", error, p.err);
          check("pass_mismatch_cnt", mismatch_cnt, p.mm);
          check("pass_last_index", max_idx, p.last);
          check("busy_low_at_done", busy, 0);
        end
        max_idx = 0;
        dones++;
      end
    end
  end

  // SCCB slave: answers each request after a random latency using the planned response.
  initial begin
    int    lat;
    resp_t r;
    sccb_ack = 1'b0; sccb_nack = 1'b0; sccb_rdata = 8'h00;
    lat = -1;
    forever begin
      @(negedge Clk);
      sccb_ack = 1'b0; sccb_nack = 1'b0;
      if (Reset || !sccb_req) lat = -1;
      else if (lat == -1) lat = $urandom_range(0, 3);
      else if (lat > 0) lat--;
      else if (lat == 0) begin
        r = (plan_q.size() > 0) ? plan_q.pop_front() : resp_t'{1'b1, 1'b0, 8'h00};
        sccb_ack = r.ack; sccb_nack = r.nack; sccb_rdata = r.rdata;
        lat = -2;
      end
    end
  end

  function automatic resp_t pick(input int nack_pct, input logic [7:0] rval);
    resp_t r;
    int    x;
    if (forced_q.size() > 0) return forced_q.pop_front();
    x = $urandom_range(0, 99);
    r.rdata = rval;
    if (x < nack_pct / 4)  begin r.ack = 1'b1; r.nack = 1'b1; end
    else if (x < nack_pct) begin r.ack = 1'b0; r.nack = 1'b1; end
    else                   begin r.ack = 1'b1; r.nack = 1'b0; end
    return r;
  endfunction

  // One SCCB transaction: first attempt plus up to MAX_RETRY retries; a nack beats a coincident ack.
  task automatic plan_txn(input logic [7:0] a, input logic [7:0] d, input logic rd, input int nack_pct,
                          output logic ok, output logic [7:0] got);
    resp_t r;
    logic [7:0] rval;
    ok = 1'b0; got = 8'h00;
    for (int att = 0; att <= MAX_RETRY && !ok; att++) begin
      rval = ($urandom_range(0, 1) == 1) ? d : 8'($urandom);
      exp_req_q.push_back('{a, d, rd});
      r = pick(nack_pct, rval);
      plan_q.push_back(r);
      if (r.ack && !r.nack) begin ok = 1'b1; got = r.rdata; end
    end
  endtask

  task automatic plan_pass(input int nack_pct);
    pass_t      p;
    logic [7:0] a, d, got;
    logic       ok;
    p.err = 1'b0; p.mm = 0; p.last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a = rom[i][15:8];
      d = rom[i][7:0];
      p.last = i;
      if (a == 8'hFF && d == 8'hFF) break;
      if (a != 8'hFF) begin
        plan_txn(a, d, 1'b0, nack_pct, ok, got);
        if (!ok) begin p.err = 1'b1; break; end
`ifdef SCCB_INIT_READBACK_EN
        plan_txn(a, d, 1'b1, nack_pct, ok, got);
        if (!ok) begin p.err = 1'b1; break; end
        if (got != d && p.mm < 255) p.mm++;
`endif
      end
    end
    exp_pass_q.push_back(p);
  endtask

  task automatic pulse_start(input logic expect_accept);
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    if (expect_accept) begin
      check("busy_after_start", busy, 1);
      check("tbl_addr_after_start", tbl_addr, 0);
      check("error_cleared_by_start", error, 0);
      check("mismatch_cleared_by_start", mismatch_cnt, 0);
    end
  endtask

  task automatic wait_done(input int d0);
    int g;
    g = 0;
    while (dones == d0 && g < 5000) begin @(negedge Clk); g++; end
    check("pass_completed", dones != d0, 1);
    repeat (2) @(negedge Clk);
    check("req_queue_drained", exp_req_q.size(), 0);
  endtask

  task automatic random_table(input logic with_markers);
    int x;
    for (int i = 0; i < DEPTH; i++) begin
      x = with_markers ? $urandom_range(0, 99) : 99;
      if (x < 8)       rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
      else if (x < 12) rom[i] = 16'hFFFF;
      else             rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    end
  endtask

  initial begin
    int n, d0, base, g;
    Reset = 1'b1; start = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
    repeat (3) @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_req", sccb_req, 0);
    check("rst_rd", sccb_rd, 0);
    check("rst_tick", sccb_tick, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_addr", sccb_addr, 0);
    check("rst_wdata", sccb_wdata, 0);
    check("rst_mismatch", mismatch_cnt, 0);

    Reset = 1'b0;
    n = 0;
    do begin @(negedge Clk); n++; end while (!sccb_tick && n < 4 * DIV);
    check("first_tick_delay", n, DIV);
    n = 0;
    do begin @(negedge Clk); n++; end while (!sccb_tick && n < 4 * DIV);
    check("tick_period", n, DIV);

    // Two writes separated by a 10-tick delay marker.
    rom[0] = 16'h1280; rom[1] = 16'hFF0A; rom[2] = 16'h40D0; rom[3] = 16'hFFFF;
    stamps.delete();
    plan_pass(0);
    d0 = dones; pulse_start(1'b1); wait_done(d0);
`ifdef SCCB_INIT_READBACK_EN
    base = 1;
`else
    base = 0;
`endif
    check("delay_req_count", stamps.size(), 2 * (base + 1));
    if (stamps.size() > base + 1) begin
      n = stamps[base + 1] - stamps[base];
      check("delay_gap_in_range", (n >= 9 * DIV) && (n <= 11 * DIV + 12), 1);
    end

    // Nack twice then ack: three attempts, no error.
    rom[0] = 16'h1101; rom[1] = 16'hFFFF;
    forced_q.push_back('{1'b0, 1'b1, 8'h00});
    forced_q.push_back('{1'b0, 1'b1, 8'h00});
    forced_q.push_back('{1'b1, 1'b0, 8'h00});
`ifdef SCCB_INIT_READBACK_EN
    forced_q.push_back('{1'b1, 1'b0, 8'h01});
`endif
    stamps.delete();
    plan_pass(0);
    d0 = dones; pulse_start(1'b1); wait_done(d0);
    check("retry_req_count", stamps.size(), 3 + base);
    check("retry_error", error, 0);

    // Permanent nack: four attempts, abort, sticky error.
    rom[0] = 16'h2233; rom[1] = 16'h4455;
    for (int i = 0; i <= MAX_RETRY; i++) forced_q.push_back('{1'b0, 1'b1, 8'h00});
    stamps.delete();
    plan_pass(0);
    d0 = dones; pulse_start(1'b1); wait_done(d0);
    check("abort_req_count", stamps.size(), MAX_RETRY + 1);
    check("abort_error_sticky", error, 1);

    // No end marker: the walk stops after the last entry.
    random_table(1'b0);
    stamps.delete();
    plan_pass(0);
    d0 = dones; pulse_start(1'b1); wait_done(d0);
    check("full_table_writes", stamps.size(), DEPTH * (base + 1));
    check("tbl_addr_stops_at_last", tbl_addr, DEPTH - 1);

`ifdef SCCB_INIT_READBACK_EN
    rom[0] = 16'h3A04; rom[1] = 16'h3B00; rom[2] = 16'hFFFF;
    forced_q.push_back('{1'b1, 1'b0, 8'h00});
    forced_q.push_back('{1'b1, 1'b0, 8'h04});
    forced_q.push_back('{1'b1, 1'b0, 8'h00});
    forced_q.push_back('{1'b1, 1'b0, 8'h10});
    plan_pass(0);
    d0 = dones; pulse_start(1'b1); wait_done(d0);
    check("readback_mismatch_cnt", mismatch_cnt, 1);
    check("readback_error", error, 0);
`endif

    // Random tables with random nacks; some passes get an ignored start while busy.
    for (int t = 0; t < 16; t++) begin
      random_table(1'b1);
      plan_pass(30);
      d0 = dones; pulse_start(1'b1);
      if (t % 2 == 1) begin
        repeat (3) @(negedge Clk);
        if (busy) pulse_start(1'b0);
      end
      wait_done(d0);
    end

    // Reset in the middle of a request.
    random_table(1'b0);
    plan_pass(0);
    d0 = dones; pulse_start(1'b1);
    g = 0;
    while (!(sccb_req && tbl_addr >= 2) && g < 2000) begin @(negedge Clk); g++; end
    check("reached_mid_transaction", sccb_req && tbl_addr >= 2, 1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_req", sccb_req, 0);
    check("async_reset_busy", busy, 0);
    exp_req_q.delete(); plan_q.delete(); exp_pass_q.delete(); forced_q.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    plan_pass(0);
    d0 = dones; pulse_start(1'b1); wait_done(d0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sccb_init_sequencer.md
# sccb_init_sequencer

Table-driven OV7670 register initialiser. It sits between a register-table ROM and the SCCB master, and owns the SCCB bit-rate tick that replaces the fixed divide-by-64 clock toggler. It walks up to DEPTH (address, data) entries, issues one SCCB write per entry with NACK retry, and honours inline delay and end markers. Optionally, it reads each register back and counts mismatches.

## Interface
- DEPTH, 32: table entries; ADDR_W = $clog2(DEPTH)
- DIV, 125: Clk cycles per SCCB tick (50 MHz / 125 = 400 kHz); legal 2..65535
- MAX_RETRY, 3: extra attempts after a NACK before abort
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a pass from entry 0
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky; set on retry exhaustion; cleared by next accepted start
- tbl_addr  out  ADDR_W  ROM index
- tbl_data  in  16  {reg_addr[15:8], reg_data[7:0]}; valid 1 cycle after tbl_addr
- sccb_tick  out  1  one-Clk pulse every DIV cycles; clocks the SCCB master
- sccb_req  out  1  transaction request; level
- sccb_rd  out  1  0 = write, 1 = read (readback only)
- sccb_addr  out  8  register address
- sccb_wdata  out  8  write data
- sccb_ack  in  1  one-cycle completion pulse
- sccb_nack  in  1  one-cycle failure pulse
- sccb_rdata  in  8  read data; valid with sccb_ack on reads
- mismatch_cnt  out  8  readback mismatches; saturates at 255

## Operation
- States: IDLE, FETCH, DECODE, WRITE, DELAY, READ, CHECK, NEXT, FINISH.
- IDLE: start=1 → FETCH, index=0, error=0, mismatch_cnt=0. A start while busy is ignored.
- FETCH: drive tbl_addr=index, then go to DECODE. DECODE samples tbl_data.
- DECODE routing:
  - addr 8'hFF, data 8'hFF → FINISH (end marker).
  - addr 8'hFF, other data → DELAY for data sccb_ticks; data 0 → NEXT immediately.
  - otherwise → WRITE.
- WRITE: assert sccb_req=1, sccb_rd=0, and hold addr/wdata stable until ack or nack.
  - ack → READ if readback is compiled in, else NEXT.
  - nack → retry while retries < MAX_RETRY; otherwise set error and go to FINISH (abort).
  - ack and nack in the same cycle: nack wins.
  - retry counter clears per entry.
- READ/CHECK: sccb_rd=1, same handshake and retry rules. On ack, compare sccb_rdata with data; a mismatch increments mismatch_cnt (saturating). No abort on mismatch.
- NEXT: index==DEPTH-1 → FINISH, else index+1 → FETCH. The index never wraps.
- FINISH: one-cycle done pulse, busy low → IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, tick counter 0. Reset asserted mid-transaction drops sccb_req immediately (async).
- sccb_tick: free-running counter 0..DIV-1, pulses when the counter reaches DIV-1. First pulse occurs DIV cycles after Reset deassertion.
- start → tbl_addr valid: 1 cycle. tbl_addr → DECODE sample: 1 cycle.
- sccb_req rises the cycle after DECODE. It falls the cycle after ack/nack. On retry, it re-asserts after at least one low cycle.
- DELAY counts sccb_tick pulses, not Clk cycles. N ticks take N×DIV cycles, ±DIV.
- done pulses exactly one cycle; busy falls in the same cycle.

## Configuration
- SCCB_INIT_READBACK_EN defined: READ/CHECK states exist; sccb_rd and mismatch_cnt are live.
- Undefined: WRITE ack goes straight to NEXT; sccb_rd and mismatch_cnt are tied 0; sccb_rdata is unused.

## Structure
- Package sccb_init_pkg:
  - state enum
  - MARK_ADDR=8'hFF, MARK_END=8'hFF
  - packed struct tbl_entry_t {reg_addr, reg_data}
- Sub-module sccb_tick_gen (DIV parameter; Clk, Reset, tick).

## Test plan
- Table {12/80, FF/0A, 40/D0, FF/FF}, ack on every request → writes 0x12=0x80 then 0x40=0xD0.
  - ~10×DIV-cycle gap between the two writes.
  - done pulse, error=0.
- Entry 0x11/0x01 with nack twice then ack, MAX_RETRY=3 → three requests to 0x11, pass completes, error=0.
- nack every attempt on entry 0 → exactly 4 requests, then error=1 and done pulse. Entries past 0 are never fetched.
- No end marker, DEPTH=4 → 4 writes, done pulse after entry 3, tbl_addr never exceeds 3.
- With SCCB_INIT_READBACK_EN, entries 0x3A/0x04 and 0x3B/0x00:
  - sccb_rdata returns 0x04, then 0x10.
  - mismatch_cnt=1, error=0.
- Reset asserted while sccb_req=1 → sccb_req=0 asynchronously, busy=0.
  - A following start restarts at tbl_addr=0.
